// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_tx_state_t;

  localparam int DATA_BITS = 8;

  // Clock cycles per serial bit, truncated.
  function automatic int baud_div(input int clk_freq_hz, input int baud_rate_bps);
    return clk_freq_hz / baud_rate_bps;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle tick every DIV cycles, held at count 0 while clear is high.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 10416
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART TX: start bit, 8 data bits LSB-first, optional even parity (UART_TX_PARITY_EN), stop bit.
// Accepts transmit one edge after request; requests are ignored while busy.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int clk_freq  = 100_000_000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       transmit,
  output logic       txd,
  output logic       busy
);

  localparam int BAUD_DIV = baud_div(clk_freq, baud_rate);

  generate
    if (BAUD_DIV < 2) begin : g_div_check
      $fatal(1, "uart_transmitter: BAUD_DIV must be >= 2");
    end
  endgenerate

  uart_tx_state_t state;
  logic [7:0]     shift;
  logic [2:0]     bit_idx;
  logic           tick;
  logic           baud_clear;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
`endif

  // Holding the timer in IDLE makes every frame's start bit a full period.
  assign baud_clear = (state == IDLE);

  uart_baud_gen #(
    .DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          txd  <= 1'b1;
          busy <= 1'b0;
          if (transmit) begin
            shift   <= data;
            bit_idx <= '0;
            state   <= START;
            txd     <= 1'b0;
            busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data;
`endif
          end
        end

        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= shift[0];
          end
        end

        DATA: begin
          if (tick) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= parity_bit;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd <= shift[1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            state <= IDLE;
            txd   <= 1'b1;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed + randomized frame checks against a bit-list model of the UART frame.
module tb_uart_transmitter;

  localparam int CLK_FREQ  = 1000;
  localparam int BAUD_RATE = 100;
  localparam int DIV       = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = 8'h00;
  logic       transmit = 1'b0;
  logic       txd;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  uart_transmitter #(
    .clk_freq  (CLK_FREQ),
    .baud_rate (BAUD_RATE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .transmit (transmit),
    .txd      (txd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Line level of bit position i of a frame carrying byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return logic'((d >> (i - 1)) & 8'd1);
`ifdef UART_TX_PARITY_EN
    if (i == 9) return logic'($countones(d) % 2);
`endif
    return 1'b1;
  endfunction

  // Called right after a negedge with the DUT idle. Optionally disturbs data/transmit mid-frame.
  task automatic send_frame(input logic [7:0] d, input bit disturb);
    int disturb_at;
    disturb_at = $urandom_range(DIV + 1, (FRAME_BITS - 2) * DIV);
    data = d;
    transmit = 1'b1;
    @(posedge clk);
    #1;
    transmit = 1'b0;
    check("accept_busy", busy, 1'b1);
    check("accept_txd", txd, 1'b0);
    for (int k = 0; k < FRAME_BITS * DIV; k++) begin
      @(negedge clk);
      check($sformatf("txd_%02h_bit%0d", d, k / DIV), txd, frame_bit(d, k / DIV));
      check("busy_in_frame", busy, 1'b1);
      if (disturb && k == disturb_at) begin
        data = 8'($urandom);
        transmit = 1'b1;
      end
      if (disturb && k == disturb_at + 3) transmit = 1'b0;
    end
    @(negedge clk);
    check("busy_after_frame", busy, 1'b0);
    check("txd_after_frame", txd, 1'b1);
  endtask

  initial begin
    logic [7:0] b;

    // Reset held: idle line, not busy.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_txd", txd, 1'b1);
      check("rst_busy", busy, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_txd", txd, 1'b1);
      check("post_rst_busy", busy, 1'b0);
    end

    // Directed frames, back-to-back with one idle cycle.
    send_frame(8'h22, 1'b0);
    send_frame(8'hA5, 1'b0);
    send_frame(8'h07, 1'b0);

    // Data changes and extra transmit requests mid-frame.
    send_frame(8'h3C, 1'b1);

    // Asynchronous reset in the middle of the data bits.
    data = 8'h00;
    transmit = 1'b1;
    @(posedge clk);
    #1;
    transmit = 1'b0;
    repeat (3 * DIV + 4) @(negedge clk);
    check("pre_abort_busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_txd", txd, 1'b1);
    check("abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_abort_txd", txd, 1'b1);
      check("post_abort_busy", busy, 1'b0);
    end
    send_frame(8'hFF, 1'b0);

    // Random bytes with random idle gaps and disturbances.
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        check("gap_txd", txd, 1'b1);
        check("gap_busy", busy, 1'b0);
      end
      send_frame(b, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
